// File: rtl/mod_mul_iter.sv
// Iterative modular multiply (interleaved radix-2, MSB-first) or modular add.
// One operation in flight; valid/ready on both sides, err flags a zero modulus.
module mod_mul_iter #(
    parameter int WIDTH = 3072,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;

    logic             accept;
    logic             take;
    logic [WIDTH+1:0] m1x, m2x, t_mul;
    logic [WIDTH:0]   t_add;
    logic [WIDTH-1:0] mul_r, add_r;

    assign accept = in_valid && in_ready;
    assign take   = vld_q && out_ready;

    // b is shifted left each MUL cycle, so its MSB is always the current bit
    assign m1x   = {2'b00, m_q};
    assign m2x   = {1'b0, m_q, 1'b0};
    assign t_mul = {1'b0, r_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    assign t_add = {1'b0, a_q} + {1'b0, b_q};

    // Subtract on the low WIDTH bits only; the wide compare picks k
    always_comb begin
        mul_r = t_mul[WIDTH-1:0];
        if (t_mul >= m2x) begin
            mul_r = t_mul[WIDTH-1:0] - m2x[WIDTH-1:0];
        end else if (t_mul >= m1x) begin
            mul_r = t_mul[WIDTH-1:0] - m_q;
        end
    end

    always_comb begin
        add_r = t_add[WIDTH-1:0];
        if (t_add >= {1'b0, m_q}) begin
            add_r = t_add[WIDTH-1:0] - m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (m == '0) begin
                        state_d = DONE;
                    end else if (mode) begin
                        state_d = ADD;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            ADD:  state_d = DONE;
            DONE: begin
                if (take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        m_d   = m_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            m_d   = m;
            r_d   = '0;
            cnt_d = CNT_W'(WIDTH - 1);
            err_d = (m == '0);
        end else if (state_q == MUL) begin
            r_d   = mul_r;
            b_d   = {b_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ADD) begin
            r_d   = add_r;
        end
    end

    // The result is presented one cycle after DONE is entered
    assign vld_d = (state_q == DONE) && !take;

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = vld_q;
        result    = r_q;
        err       = vld_q & err_q;
    end

endmodule

// File: doc/mod_mul_iter.md
# mod_mul_iter

Parametrised, iterative modular arithmetic unit computing `(a*b) mod m` (interleaved radix-2, MSB-first) or `(a+b) mod m`. It is the successor to the fixed-width, single-operation phase_a datapath. It generalises operand width and adds an operation-mode select, a valid/ready handshake on both sides, and a modulus-zero error flag. It sits between operand staging registers and the exponentiation sequencer in the RSA datapath.

## Interface

Parameters:
- `WIDTH`, 3072: operand and modulus width in bits; legal range ≥ 2.
- `CNT_W`, `$clog2(WIDTH+1)`: derived width of the bit counter; not overridden.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operand bundle valid.
- `in_ready`, out, 1: block can accept an operand bundle.
- `mode`, in, 1: 0 = modular multiply, 1 = modular add; sampled on accept.
- `a`, in, WIDTH: operand A; required `a < m`.
- `b`, in, WIDTH: operand B; required `b < m`.
- `m`, in, WIDTH: modulus.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `result`, out, WIDTH: `(a*b) mod m` or `(a+b) mod m`.
- `err`, out, 1: qualified by `out_valid`; 1 when `m == 0`.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- Accept occurs on a rising edge where `in_valid && in_ready`. On accept, `a`, `b`, `m` and `mode` are captured into internal registers. Inputs are don't-care after that edge.
- The FSM states are IDLE, MUL, ADD and DONE.
  - IDLE: `in_ready=1`. On accept, go to DONE if `m==0`, to ADD if `mode=1`, otherwise to MUL.
  - MUL: one bit of `b` is processed per cycle, from bit WIDTH-1 down to bit 0. The counter loads WIDTH-1 on accept and decrements. Each cycle computes `t = 2r + (b[i] ? a : 0)` at WIDTH+2 bits. Then `r = t - k*m`, where k ∈ {0,1,2} is the largest value with `t - k*m ≥ 0`. Both comparisons (`t ≥ 2m`, `t ≥ m`) are done in the same cycle. `r` is cleared on accept. After bit 0 the state goes to DONE.
  - ADD: a single cycle. `t = a + b` at WIDTH+1 bits; `r = (t ≥ m) ? t - m : t`. Then go to DONE.
  - DONE: `out_valid=1`, with `result=r[WIDTH-1:0]` and `err` held stable. When `out_valid && out_ready`, return to IDLE.
- Error path: when `m==0`, `result=0` and `err=1`, and no arithmetic is performed.
- Out-of-contract operands (`a ≥ m` or `b ≥ m`, with `m ≠ 0`): `result` is unspecified, but latency and handshake behaviour must be identical to the legal case. The block must never hang.
- One operation is in flight at a time. `in_ready` is 0 in MUL, ADD and DONE.

## Timing

- Reset values: `in_ready=1`, `out_valid=0`, `result=0`, `err=0`, `busy=0`. FSM = IDLE, counter = 0, `r=0`.
- If `rst_n` is asserted mid-operation, the block returns to IDLE immediately (asynchronously). The in-flight operation is discarded and no `out_valid` is produced for it.
- Counting the accept edge as edge 0, `out_valid` rises after:
  - MUL: edge WIDTH+1.
  - ADD: edge 2.
  - `m==0` error: edge 1.
- Back-pressure: `out_valid` stays high and `result` and `err` stay stable until `out_ready`. There is no limit on the stall length.
- `in_ready` rises on the edge where the result is taken, so the earliest next accept is the following edge. There is no same-cycle turnaround.
- `in_valid` asserted while `in_ready=0` is ignored and not queued.
- `out_ready` is ignored while `out_valid=0`.

## Test plan

- WIDTH=8, MUL, `a=200`, `b=150`, `m=251`, `out_ready=1` -> `out_valid` at edge 9, `result=131`, `err=0`, then `in_ready=1` on the next cycle.
- WIDTH=8, ADD, `a=200`, `b=150`, `m=251` -> `out_valid` at edge 2, `result=99`. Also `a=3`, `b=4`, `m=251` -> `result=7` (no subtract).
- WIDTH=8, `m=0`, either mode -> `out_valid` at edge 1, `err=1`, `result=0`. Next operation with `m=251` -> `err=0`.
- WIDTH=8, MUL `a=250`, `b=250`, `m=251`, `out_ready` held low for 20 cycles -> `result=1` is stable throughout the stall. `in_valid` pulses during the stall are not accepted. Two back-to-back operations complete in order.
- WIDTH=8, assert `rst_n=0` at edge 4 of a MUL -> all outputs return to reset values at once, and no `out_valid` appears. A fresh MUL `a=2`, `b=3`, `m=7` then gives `result=6`.
- WIDTH=3072, MUL with the same `a` and `m` used in the phase_a bench, and `b=1` -> `result=a`, `out_valid` at edge 3073, compared against the Python golden model.
